mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer sharing the single-port 32-bit word memory between N_REQ requesters (e.g. instruction fetch, data load/store, DMA).
- Accepts one request at a time and drives the memory start/ready handshake.
- Returns read data, or write completion, to the granted requester with a one-cycle ack.
- Rejects out-of-range addresses without touching the memory.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 16, address width on requester and memory sides
DATA_W, 32, data width
ADDR_LIMIT, 4096, first illegal word address; requests with addr >= ADDR_LIMIT are rejected

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester request, held high until its ack
req_rwn  input  N_REQ  per-requester 1=read, 0=write
req_addr  input  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  N_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
ack  output  N_REQ  one-hot, one-cycle completion pulse
err  output  1  valid with ack; 1 = address out of range, no access done
rdata  output  DATA_W  read data, valid while ack is high on a read
grant_id  output  3  index of requester currently owning the memory
busy  output  1  high in any state other than IDLE
mem_start  output  1  memory start strobe
mem_rwn  output  1  memory read/write select
mem_address  output  ADDR_W  memory address
mem_data_in  output  DATA_W  memory write data
mem_data_out  input  DATA_W  memory read data
mem_ready  input  1  memory idle flag (low for exactly one cycle after an accepted start)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer last = N_REQ-1, so requester 0 has first priority.
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE.
- IDLE:
  - If any req bit is high, select the first requester with req high, searching from last+1 modulo N_REQ.
  - Register grant_id, and latch that requester's rwn/addr/wdata into mem_rwn/mem_address/mem_data_in.
  - Update last to the winner.
  - If addr >= ADDR_LIMIT, go to DONE with err latched to 1; otherwise go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE:
  - mem_start=1 only while mem_ready=1; if mem_ready=0, hold mem_start=0 and stay in ISSUE.
  - Go to WAIT_LO on the edge where mem_start=1.
  - mem_start is high for exactly one cycle per access.
- WAIT_LO: wait for mem_ready=0, then go to WAIT_HI.
- WAIT_HI:
  - On mem_ready=1, go to DONE.
  - Latch mem_data_out into rdata if mem_rwn=1; on a write, rdata is unchanged.
- DONE:
  - ack[grant_id]=1 for one cycle and err is valid.
  - Clear err on exit; next state is IDLE.
- Latency: req sampled in IDLE at cycle 0 -> mem_start in cycle 1 -> ack in cycle 4. The out-of-range ack comes in cycle 1.
- Requester rule:
  - req and its rwn/addr/wdata stay stable until ack.
  - The requester drops req on the edge where it samples ack.
  - IDLE re-arbitrates the following cycle.
  - A req still high in IDLE is treated as a new request.
- Request bits that rise during a transaction wait; no request is lost or reordered beyond the round-robin order.
- mem_address/mem_rwn/mem_data_in hold their values from IDLE grant through DONE; they are don't-care in IDLE.
- Reset mid-transaction: immediate return to IDLE and all outputs cleared. No ack is issued for the aborted request; the requester re-requests.

Test Plan:
- Single requester 0: write addr 0x0010 data 0xDEADBEEF, then read 0x0010 -> write ack[0] in cycle 4 with err=0; read ack[0] with rdata=0xDEADBEEF; mem_start high exactly one cycle per access.
- req=2'b11 simultaneously after reset, both reads -> requester 0 acked first, then requester 1; grant_id 0 then 1.
- Both requesters continuously re-requesting for 6 transactions -> ack order 0,1,0,1,0,1; no starvation.
- Requester 1 reads addr 0x1000 (== ADDR_LIMIT) -> ack[1] in cycle 1 with err=1; mem_start never asserted; next legal request has err=0.
- Requester 0 writes 0x0005=0x12345678 while requester 1 requests a read of 0x0005 one cycle later -> requester 1 gets rdata=0x12345678 after requester 0's ack.
- Assert reset in WAIT_LO -> ack, mem_start and busy go 0 immediately; after release, a new request completes normally with 4-cycle latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port word memory between
// N_REQ requesters; out-of-range addresses are acked with err, no memory access.
//
// state   | meaning
// IDLE    | pick next requester round-robin from last+1, latch its command
// ISSUE   | pulse mem_start once the memory reports ready
// WAIT_LO | wait for the memory to drop ready (access accepted)
// WAIT_HI | wait for ready to return, capture read data
// DONE    | one-cycle ack to the granted requester, err valid
module mem_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int ADDR_LIMIT = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_rwn,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  output logic [N_REQ-1:0]           ack,
  output logic                       err,
  output logic [DATA_W-1:0]          rdata,
  output logic [2:0]                 grant_id,
  output logic                       busy,
  output logic                       mem_start,
  output logic                       mem_rwn,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_data_in,
  input  logic [DATA_W-1:0]          mem_data_out,
  input  logic                       mem_ready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_LO = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  logic [2:0]        last;
  logic [2:0]        win_id;
  logic              win_vld;
  logic [N_REQ-1:0]  req_sh;
  logic [N_REQ-1:0]  rwn_sh;
  logic              sel_rwn;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oob;

  // Search order starts just after the previous winner, so a requester that
  // was just served has the lowest priority in the next arbitration.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    req_sh  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      req_sh = req >> ((int'(last) + k) % N_REQ);
      if (!win_vld && req_sh[0]) begin
        win_vld = 1'b1;
        win_id  = 3'((int'(last) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    rwn_sh    = req_rwn >> win_id;
    sel_rwn   = rwn_sh[0];
    sel_addr  = ADDR_W'(req_addr >> (win_id * ADDR_W));
    sel_wdata = DATA_W'(req_wdata >> (win_id * DATA_W));
    sel_oob   = 32'(sel_addr) >= 32'(ADDR_LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last        <= 3'(N_REQ - 1);
      grant_id    <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      mem_rwn     <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            grant_id    <= win_id;
            last        <= win_id;
            mem_rwn     <= sel_rwn;
            mem_address <= sel_addr;
            mem_data_in <= sel_wdata;
            if (sel_oob) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ready) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!mem_ready) state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (mem_ready) begin
            if (mem_rwn) rdata <= mem_data_out;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Start is gated by ready so a busy memory never sees a dropped strobe.
  assign mem_start = (state == S_ISSUE) && mem_ready;
  assign busy      = (state != S_IDLE);

  always_comb begin
    ack = '0;
    if (state == S_DONE) ack = N_REQ'(1) << grant_id;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with per-cycle
// compare, a well-behaved single-port memory, directed and random traffic.
module tb_mem_arbiter;
  localparam int N_REQ      = 2;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int ADDR_LIMIT = 4096;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ-1:0]        req_rwn = '0;
  logic [N_REQ*ADDR_W-1:0] req_addr = '0;
  logic [N_REQ*DATA_W-1:0] req_wdata = '0;
  logic [N_REQ-1:0]        ack;
  logic                    err;
  logic [DATA_W-1:0]       rdata;
  logic [2:0]              grant_id;
  logic                    busy, mem_start, mem_rwn;
  logic [ADDR_W-1:0]       mem_address;
  logic [DATA_W-1:0]       mem_data_in;
  logic [DATA_W-1:0]       mem_data_out = '0;
  logic                    mem_ready;
  logic                    mem_hold = 1'b0;
  logic                    dev_low = 1'b0;
  logic                    mem_inited = 1'b0;
  logic [31:0]             dev_mem [0:4095];

  always #5 clk = ~clk;

  mem_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_LIMIT(ADDR_LIMIT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rwn(req_rwn), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .grant_id(grant_id),
    .busy(busy), .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready));

  function automatic logic [31:0] init_val(int k);
    return 32'hA5C3_0000 ^ (32'(k) * 32'h9E37_79B1);
  endfunction

  // Memory device: ready drops for exactly one cycle after an accepted start.
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int k = 0; k < 4096; k++) dev_mem[k] <= init_val(k);
      mem_inited <= 1'b1;
    end
    if (mem_start && mem_ready) begin
      if (mem_rwn) mem_data_out <= dev_mem[mem_address[11:0]];
      else         dev_mem[mem_address[11:0]] <= mem_data_in;
    end
    dev_low <= mem_start && mem_ready;
  end
  assign mem_ready = !dev_low && !mem_hold;

  // Reference model state
  logic [31:0]       ref_mem [0:4095];
  bit                m_active, m_rwn, m_oob;
  int                m_k, m_ackk, m_win, m_last;
  logic [15:0]       m_addr;
  logic [31:0]       m_wdata, m_rdata;

  int                checks = 0, errors = 0;
  logic [N_REQ-1:0]  obs_ack;
  logic              obs_err;
  logic [31:0]       obs_rdata;
  logic [2:0]        obs_gid;
  int                starts = 0;
  int                wait_cnt [N_REQ];
  int                ack_q [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_ackk   = 0;
    m_last   = N_REQ - 1;
    m_rdata  = '0;
  endtask

  task automatic raise(int i, bit rwn, logic [15:0] a, logic [31:0] d);
    req[i]                        = 1'b1;
    req_rwn[i]                    = rwn;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    wait_cnt[i]                   = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, then release
  // acked requesters just after the rising edge.
  task automatic step();
    logic [N_REQ-1:0] e_ack;
    logic [31:0]      e_rdata;
    bit               ackcyc, e_start, found;
    int               idx;
    @(negedge clk);
    ackcyc  = m_active && (m_k == m_ackk);
    e_ack   = ackcyc ? (N_REQ'(1) << m_win) : '0;
    e_start = m_active && !m_oob && (m_k == 1) && mem_ready;
    e_rdata = (ackcyc && !m_oob && m_rwn) ? ref_mem[m_addr[11:0]] : m_rdata;
    chk("ack", 64'(ack), 64'(e_ack));
    chk("err", 64'(err), 64'(ackcyc && m_oob));
    chk("busy", 64'(busy), 64'(m_active));
    chk("mem_start", 64'(mem_start), 64'(e_start));
    chk("rdata", 64'(rdata), 64'(e_rdata));
    if (m_active) begin
      chk("grant_id", 64'(grant_id), 64'(m_win));
      chk("mem_rwn", 64'(mem_rwn), 64'(m_rwn));
      chk("mem_address", 64'(mem_address), 64'(m_addr));
      chk("mem_data_in", 64'(mem_data_in), 64'(m_wdata));
    end
    obs_ack = ack; obs_err = err; obs_rdata = rdata; obs_gid = grant_id;
    if (mem_start) starts++;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) wait_cnt[i]++;
      if (ack[i]) begin
        ack_q.push_back(i);
        chk("ack_wait", 64'(wait_cnt[i] <= 100), 64'(1));
      end
    end
    m_rdata = e_rdata;
    if (reset) begin
      model_reset();
    end else if (m_active) begin
      if (ackcyc) begin
        if (!m_oob && !m_rwn) ref_mem[m_addr[11:0]] = m_wdata;
        m_active = 1'b0;
      end else if (!((m_k == 1) && !m_oob && !mem_ready)) begin
        m_k++;
      end
    end else if (|req) begin
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (m_last + k) % N_REQ;
        if (!found && req[idx]) begin
          found    = 1'b1;
          m_win    = idx;
          m_last   = idx;
          m_rwn    = req_rwn[idx];
          m_addr   = req_addr[idx*ADDR_W +: ADDR_W];
          m_wdata  = req_wdata[idx*DATA_W +: DATA_W];
          m_oob    = m_addr >= ADDR_LIMIT;
          m_ackk   = m_oob ? 1 : 4;
          m_k      = 1;
          m_active = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) if (obs_ack[i]) req[i] = 1'b0;
  endtask

  task automatic run_until_any(int maxc, output int cyc);
    cyc = -1;
    for (int c = 0; c < maxc; c++) begin
      step();
      if (|obs_ack) begin
        cyc = c;
        break;
      end
    end
    if (cyc < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ack within %0d cycles at %0t", maxc, $time);
    end
  endtask

  task automatic drain();
    mem_hold = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (req == '0 && !m_active) return;
      step();
    end
    checks++; errors++;
    $display("FAIL drain_timeout: req=%0b still pending", req);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, s0, r;
    int exp_ord [6] = '{0, 1, 0, 1, 0, 1};
    logic [15:0] a;
    for (int k = 0; k < 4096; k++) ref_mem[k] = init_val(k);
    for (int i = 0; i < N_REQ; i++) wait_cnt[i] = 0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_gid", 64'(grant_id), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_start", 64'(mem_start), 64'(0));
    chk("rst_maddr", 64'(mem_address), 64'(0));
    chk("rst_mdin", 64'(mem_data_in), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Single requester write then read-back
    s0 = starts;
    raise(0, 1'b0, 16'h0010, 32'hDEAD_BEEF);
    run_until_any(20, cyc);
    chk("t1_wr_lat", 64'(cyc), 64'(4));
    chk("t1_wr_ack", 64'(obs_ack), 64'(2'b01));
    chk("t1_wr_err", 64'(obs_err), 64'(0));
    chk("t1_wr_starts", 64'(starts - s0), 64'(1));
    s0 = starts;
    raise(0, 1'b1, 16'h0010, 32'h0);
    run_until_any(20, cyc);
    chk("t1_rd_lat", 64'(cyc), 64'(4));
    chk("t1_rd_data", 64'(obs_rdata), 64'(32'hDEAD_BEEF));
    chk("t1_rd_starts", 64'(starts - s0), 64'(1));

    // Simultaneous requests after reset: requester 0 first
    reset = 1'b1; #1; model_reset();
    step();
    reset = 1'b0;
    raise(0, 1'b1, 16'h0010, 32'h0);
    raise(1, 1'b1, 16'h0003, 32'h0);
    run_until_any(20, cyc);
    chk("t2_first_ack", 64'(obs_ack), 64'(2'b01));
    chk("t2_first_gid", 64'(obs_gid), 64'(0));
    run_until_any(20, cyc);
    chk("t2_second_ack", 64'(obs_ack), 64'(2'b10));
    chk("t2_second_gid", 64'(obs_gid), 64'(1));
    chk("t2_second_lat", 64'(cyc), 64'(4));

    // Continuous re-requesting alternates fairly
    ack_q.delete();
    raise(0, 1'b1, 16'h0001, 32'h0);
    raise(1, 1'b1, 16'h0002, 32'h0);
    for (int c = 0; c < 100 && ack_q.size() < 6; c++) begin
      step();
      for (int i = 0; i < N_REQ; i++)
        if (obs_ack[i] && ack_q.size() < 6)
          raise(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
    end
    if (ack_q.size() < 6) begin
      checks++; errors++;
      $display("FAIL t3_count: got %0d acks want 6", ack_q.size());
    end else begin
      for (int k = 0; k < 6; k++) chk("t3_order", 64'(ack_q[k]), 64'(exp_ord[k]));
    end
    drain();

    // Out-of-range address, then a legal one
    s0 = starts;
    raise(1, 1'b1, 16'h1000, 32'h0);
    run_until_any(20, cyc);
    chk("t4_oob_lat", 64'(cyc), 64'(1));
    chk("t4_oob_ack", 64'(obs_ack), 64'(2'b10));
    chk("t4_oob_err", 64'(obs_err), 64'(1));
    chk("t4_oob_starts", 64'(starts - s0), 64'(0));
    raise(1, 1'b1, 16'h0010, 32'h0);
    run_until_any(20, cyc);
    chk("t4_legal_err", 64'(obs_err), 64'(0));
    chk("t4_legal_data", 64'(obs_rdata), 64'(32'hDEAD_BEEF));

    // Write by 0, read of same word by 1 arriving a cycle later
    raise(0, 1'b0, 16'h0005, 32'h1234_5678);
    step();
    raise(1, 1'b1, 16'h0005, 32'h0);
    run_until_any(20, cyc);
    chk("t5_wr_ack", 64'(obs_ack), 64'(2'b01));
    run_until_any(20, cyc);
    chk("t5_rd_ack", 64'(obs_ack), 64'(2'b10));
    chk("t5_rd_data", 64'(obs_rdata), 64'(32'h1234_5678));

    // Memory not ready while issuing: start is deferred, not lost
    s0 = starts;
    mem_hold = 1'b1;
    raise(0, 1'b1, 16'h0005, 32'h0);
    step(); step(); step();
    mem_hold = 1'b0;
    run_until_any(20, cyc);
    chk("t6_hold_lat", 64'(cyc + 3), 64'(6));
    chk("t6_hold_data", 64'(obs_rdata), 64'(32'h1234_5678));
    chk("t6_hold_starts", 64'(starts - s0), 64'(1));

    // Reset while waiting on the memory
    raise(0, 1'b1, 16'h0010, 32'h0);
    step(); step();
    reset = 1'b1;
    #1;
    chk("t7_rst_ack", 64'(ack), 64'(0));
    chk("t7_rst_start", 64'(mem_start), 64'(0));
    chk("t7_rst_busy", 64'(busy), 64'(0));
    model_reset();
    step();
    reset = 1'b0;
    run_until_any(20, cyc);
    chk("t7_after_lat", 64'(cyc), 64'(4));
    chk("t7_after_data", 64'(obs_rdata), 64'(32'hDEAD_BEEF));

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      step();
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          r = int'($urandom_range(0, 9));
          if (r == 0)      a = 16'($urandom_range(4096, 65535));
          else if (r == 1) a = ($urandom_range(0, 1) == 1) ? 16'h0FFF : 16'h1000;
          else             a = 16'($urandom_range(0, 31));
          raise(i, 1'($urandom_range(0, 1)), a, $urandom);
        end
      end
      mem_hold = (!m_active || m_k == 1) && ($urandom_range(0, 3) == 0);
    end
    drain();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
